// File: rtl/mio_pkg.sv
// Shared types and constants for the memory/IO bus slave.
package mio_pkg;

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;
   typedef enum logic [1:0] {T_RAM, T_IO, T_NONE} target_e;

   localparam logic [3:0]  OFF_GPIO        = 4'h0;
   localparam logic [3:0]  OFF_CNT         = 4'h4;
   localparam logic [31:0] IO_BASE_DEFAULT = 32'hF000_0000;

endpackage

// File: rtl/mio_io_regs.sv
// IO page registers: GPIO output latch, free-running cycle counter and read mux.
module mio_io_regs
   import mio_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        we,
   input  logic [3:0]  offset,
   input  logic [31:0] wdata,
   input  logic [15:0] switch_in,
   output logic [15:0] led_out,
   output logic [31:0] rdata
);

   logic [15:0] led_q, led_d;
   logic [31:0] cnt_q, cnt_d;

   // A CPU write to the counter wins over the increment in the same cycle.
   always_comb begin
      led_d = led_q;
      cnt_d = cnt_q + 32'd1;
      if (we && (offset == OFF_GPIO)) led_d = wdata[15:0];
      if (we && (offset == OFF_CNT))  cnt_d = wdata;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         led_q <= '0;
         cnt_q <= '0;
      end else begin
         led_q <= led_d;
         cnt_q <= cnt_d;
      end
   end

   always_comb begin
      rdata = '0;
      case (offset)
         OFF_GPIO: rdata = {16'h0000, switch_in};
         OFF_CNT:  rdata = cnt_q;
         default:  rdata = '0;
      endcase
   end

   assign led_out = led_q;

endmodule

// File: rtl/mio_bus.sv
// Memory/IO bus slave for the multicycle CPU: decodes requests to RAM, IO
// registers or unmapped space and returns registered read data plus a ready pulse.
module mio_bus
   import mio_pkg::*;
#(
   parameter int unsigned RAM_AW   = 10,
   parameter int unsigned RAM_WAIT = 0,
   parameter logic [31:0] IO_BASE  = IO_BASE_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic              CPU_MIO,
   input  logic [31:0]       Addr_out,
   input  logic [31:0]       Data_out,
   output logic [31:0]       Data_in,
   output logic              MIO_ready,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [31:0]       ram_din,
   output logic              ram_we,
   input  logic [31:0]       ram_dout,
   input  logic [15:0]       switch_in,
   output logic [15:0]       led_out,
   output logic              bus_err
);

   state_e      state_q, state_d;
   logic [3:0]  wcnt_q, wcnt_d;
   logic [31:0] data_in_q, data_in_d;
   logic        ready_q, ready_d;
   logic        err_q, err_d;

   target_e     target;
   logic        req, rd_ok, wr_ok, illegal, io_mapped, final_cyc, io_we;
   logic [3:0]  offset;
   logic [31:0] io_rdata;

   assign req       = CPU_MIO & (MemRead | MemWrite);
   assign rd_ok     = CPU_MIO & MemRead & ~MemWrite;
   assign wr_ok     = CPU_MIO & MemWrite & ~MemRead;
   assign illegal   = CPU_MIO & MemRead & MemWrite;
   assign offset    = Addr_out[3:0] & 4'hC;
   assign io_mapped = (offset == OFF_GPIO) || (offset == OFF_CNT);

   always_comb begin
      target = T_NONE;
      if (Addr_out[31:RAM_AW+2] == '0)           target = T_RAM;
      else if (Addr_out[31:4] == IO_BASE[31:4])  target = T_IO;
   end

   assign final_cyc = (state_q == ACCESS) && (wcnt_q == '0);
   assign ram_we    = final_cyc && wr_ok && (target == T_RAM);
   assign io_we     = final_cyc && wr_ok && (target == T_IO);
   assign ram_addr  = Addr_out[RAM_AW+1:2];
   assign ram_din   = Data_out;

   mio_io_regs u_io_regs (
      .clk       (clk),
      .reset     (reset),
      .we        (io_we),
      .offset    (offset),
      .wdata     (Data_out),
      .switch_in (switch_in),
      .led_out   (led_out),
      .rdata     (io_rdata)
   );

   // Writes leave Data_in untouched; reads and illegal requests capture into it.
   always_comb begin
      state_d   = state_q;
      wcnt_d    = wcnt_q;
      data_in_d = data_in_q;
      ready_d   = 1'b0;
      err_d     = err_q;
      case (state_q)
         IDLE: begin
            if (req) begin
               state_d = ACCESS;
               wcnt_d  = (target == T_RAM) ? 4'(RAM_WAIT) : '0;
            end
         end
         ACCESS: begin
            if (wcnt_q != '0) begin
               wcnt_d = wcnt_q - 4'd1;
            end else begin
               state_d = DONE;
               ready_d = 1'b1;
               if (illegal) begin
                  data_in_d = '0;
                  err_d     = 1'b1;
               end else if (rd_ok) begin
                  case (target)
                     T_RAM:   data_in_d = ram_dout;
                     T_IO:    data_in_d = io_rdata;
                     default: data_in_d = '0;
                  endcase
               end
               if ((rd_ok || wr_ok) &&
                   ((target == T_NONE) || ((target == T_IO) && !io_mapped)))
                  err_d = 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         wcnt_q    <= '0;
         data_in_q <= '0;
         ready_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         wcnt_q    <= wcnt_d;
         data_in_q <= data_in_d;
         ready_q   <= ready_d;
         err_q     <= err_d;
      end
   end

   assign Data_in   = data_in_q;
   assign MIO_ready = ready_q;
   assign bus_err   = err_q;

endmodule
